// File: rtl/s2qed_pkg.sv
// Shared constants for the WISHBONE scratch memory.
//   ST_*            FSM state encoding used by s2qed_wb_mem
//   AW_DEF/WAIT_DEF default word-address width and wait-state count
//   LANE_W/N_LANES  byte-lane width and lane count of the 32-bit data bus
//   CNT_W           wait counter width (covers WAIT up to 15)
package s2qed_pkg;

   localparam int DATA_W   = 32;
   localparam int LANE_W   = 8;
   localparam int N_LANES  = DATA_W / LANE_W;
   localparam int AW_DEF   = 8;
   localparam int WAIT_DEF = 1;
   localparam int CNT_W    = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_ACK  = 2'd2;

endpackage

// File: rtl/s2qed_wb_ram.sv
// Single-port word memory with per-byte write enables.
//   clk    write clock
//   we     write strobe; only lanes with be[i]=1 are updated
//   be     byte enables, bit i covers wdata[8i+7:8i]
//   addr   word address
//   wdata  write data
//   rdata  combinational read of mem[addr]
// No reset: contents survive a controller reset.
module s2qed_wb_ram
   import s2qed_pkg::*;
#(
   parameter int AW = AW_DEF
) (
   input  logic                clk,
   input  logic                we,
   input  logic [N_LANES-1:0]  be,
   input  logic [AW-1:0]       addr,
   input  logic [DATA_W-1:0]   wdata,
   output logic [DATA_W-1:0]   rdata
);

   logic [DATA_W-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      for (int i = 0; i < N_LANES; i++) begin
         if (we && be[i]) begin
            mem[addr][LANE_W*i +: LANE_W] <= wdata[LANE_W*i +: LANE_W];
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/s2qed_wb_mem.sv
// WISHBONE slave memory with a programmable number of wait states.
//   CLK, RST      clock and synchronous active-low reset
//   CYC_O, STB_O  cycle / strobe from the CPU
//   ADR_O         byte address; word index is ADR_O[AW+1:2], rest ignored
//   DAT_O, WE_O   write data and direction (1 = write)
//   SEL_O         byte-lane enables
//   ACK_I         single-cycle acknowledge
//   DAT_I         read data, zero outside a read acknowledge
//   TAG0_I        constant fetch-width tag (IF_WIDTH)
//
// state   | meaning
// --------+-------------------------------------------------------
// IDLE    | waiting for CYC&STB; request fields latched on entry
// WAIT    | counting down wait states, leaves when counter hits 1
// ACK     | ACK_I asserted, write committed at the closing edge
module s2qed_wb_mem
   import s2qed_pkg::*;
#(
   parameter int AW       = AW_DEF,
   parameter int WAIT     = WAIT_DEF,
   parameter int IF_WIDTH = 0
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                CYC_O,
   input  logic                STB_O,
   input  logic [31:0]         ADR_O,
   input  logic [31:0]         DAT_O,
   input  logic                WE_O,
   input  logic [3:0]          SEL_O,
   output logic                ACK_I,
   output logic [31:0]         DAT_I,
   output logic                TAG0_I
);

   localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT);

   logic [1:0]          state;
   logic [CNT_W-1:0]    cnt;
   logic [AW-1:0]       adr_q;
   logic [DATA_W-1:0]   dat_q;
   logic                we_q;
   logic [N_LANES-1:0]  sel_q;
   logic                req;
   logic                ack;
   logic [DATA_W-1:0]   rdata;
   logic                unused_adr;

   assign req = CYC_O & STB_O;

   // Gating with req and RST makes an abort or a reset in the ACK cycle
   // suppress both the acknowledge and the write in the same cycle.
   assign ack = (state == ST_ACK) & req & RST;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req) begin
                  cnt   <= WAIT_LD;
                  state <= (WAIT == 0) ? ST_ACK : ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (!req) begin
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
                  if (cnt == CNT_W'(1)) begin
                     state <= ST_ACK;
                  end
               end
            end
            ST_ACK:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Request fields are captured only on acceptance so later bus changes
   // cannot disturb the transfer in flight.
   always_ff @(posedge CLK) begin
      if (RST && state == ST_IDLE && req) begin
         adr_q <= ADR_O[AW+1:2];
         dat_q <= DAT_O;
         we_q  <= WE_O;
         sel_q <= SEL_O;
      end
   end

   s2qed_wb_ram #(.AW(AW)) u_ram (
      .clk   (CLK),
      .we    (ack & we_q),
      .be    (sel_q),
      .addr  (adr_q),
      .wdata (dat_q),
      .rdata (rdata)
   );

   assign ACK_I  = ack;
   assign DAT_I  = (ack && !we_q) ? rdata : '0;
   assign TAG0_I = 1'(IF_WIDTH);

   assign unused_adr = ^{ADR_O[31:AW+2], ADR_O[1:0]};

endmodule

// File: doc/s2qed_wb_mem.md
S2QED_WB_MEM -- requirements
Module: s2qed_wb_mem

Interface
REQ-001 Parameter AW, default 8: word-address width; memory depth is 2^AW 32-bit words.
REQ-002 Parameter WAIT, default 1: wait states inserted before ACK_I, legal range 0..15.
REQ-003 Parameter IF_WIDTH, default 0: constant value driven on TAG0_I.
REQ-004 CLK  in  1  single system clock; all state updates on its rising edge.
REQ-005 RST  in  1  reset, synchronous, active-low.
REQ-006 CYC_O  in  1  WISHBONE cycle from the CPU.
REQ-007 STB_O  in  1  WISHBONE strobe from the CPU.
REQ-008 ADR_O  in  32  byte address from the CPU.
REQ-009 DAT_O  in  32  write data from the CPU.
REQ-010 WE_O  in  1  1 = write, 0 = read.
REQ-011 SEL_O  in  4  byte-lane enables; bit i covers data bits [8i+7:8i].
REQ-012 ACK_I  out  1  transfer acknowledge to the CPU.
REQ-013 DAT_I  out  32  read data to the CPU.
REQ-014 TAG0_I  out  1  fetch width; equals IF_WIDTH at all times.

Function
REQ-015 The block shall implement a three-state FSM: IDLE, WAIT, ACK.
REQ-016 In IDLE with CYC_O=1 and STB_O=1, the block shall latch ADR_O[AW+1:2], DAT_O, WE_O and SEL_O and load the wait counter with WAIT.
REQ-017 From IDLE on a request, the FSM shall go to ACK if WAIT=0, otherwise to WAIT.
REQ-018 In WAIT, the counter shall decrement each cycle, and the FSM shall go to ACK in the cycle the counter reaches 1.
REQ-019 ACK_I shall be 1 for exactly one cycle, only in state ACK; ACK shall always return to IDLE.
REQ-020 Latency: a request first sampled at edge n shall see ACK_I=1 during cycle n+1+WAIT.
REQ-021 Back-to-back transfers: a new request shall be sampled no earlier than the IDLE cycle after ACK; minimum spacing is WAIT+2 cycles.
REQ-022 Reads: DAT_I shall carry mem[latched address] during the ACK cycle and 0 in every other cycle.
REQ-023 Writes: at the ACK edge, only byte lanes whose SEL bit is set shall be written; other lanes shall keep their value.
REQ-024 During a write ACK, DAT_I shall be 0.
REQ-025 ADR_O[1:0] and ADR_O[31:AW+2] shall be ignored; addresses alias modulo 2^AW words.
REQ-026 Abort: if CYC_O or STB_O is 0 in WAIT or ACK, the FSM shall return to IDLE, ACK_I shall stay 0, and no write shall occur.
REQ-027 A write with SEL_O=4'b0000 shall be acknowledged normally and shall modify nothing.
REQ-028 Inputs that change after latching (ADR_O, DAT_O, WE_O, SEL_O) shall not affect the transfer in progress.

Reset
REQ-029 While RST=0 at a clock edge, the FSM shall go to IDLE, the wait counter shall clear, and ACK_I and DAT_I shall be 0.
REQ-030 Reset shall not clear memory contents.
REQ-031 Reset asserted mid-transfer shall cancel the transfer: no ACK and no write.
REQ-032 TAG0_I shall equal IF_WIDTH during and after reset.

Structure
REQ-033 Package s2qed_pkg shall hold the FSM state encoding, the WAIT and AW defaults, and the byte-lane width constant.
REQ-034 Storage shall be a sub-module s2qed_wb_ram: single-port, synchronous write with 4 byte enables, combinational read, depth 2^AW.
REQ-035 The top-level harness shall be able to instantiate one block so that both CPU copies receive identical responses.

Verification
REQ-036 WAIT=1: write 0xDEADBEEF to 0x10 with SEL=1111 -> ACK_I in cycle n+2; read 0x10 -> DAT_I=0xDEADBEEF with ACK.
REQ-037 Preload 0x11223344 at 0x20; write 0xAABBCCDD with SEL=0101 -> read returns 0x11BB33DD.
REQ-038 WAIT=0: back-to-back reads of 0x0 and 0x4 with STB held -> ACK_I pattern 1,0,1 across cycles n+1..n+3.
REQ-039 WAIT=3: write request, STB_O dropped in the 2nd WAIT cycle -> no ACK_I, memory unchanged, FSM in IDLE.
REQ-040 AW=8: write 0x5 to 0x400, then read 0x000 -> 0x5 (alias); read 0x003 -> same word.
REQ-041 RST=0 during a write's ACK cycle -> ACK_I=0, DAT_I=0, no write; a word written before reset still reads back afterwards.
